qspi_mem_responder: RTL and testbench
=====================================

Name: qspi_mem_responder

Overview:
Synthesisable QSPI memory responder: the device end of the QSPI link driven by tinyqv_mem_ctrl. It models one flash or PSRAM chip behind one select line, and it decodes command, address, mode/dummy and data phases. It returns read nibbles from an internal byte array or commits write nibbles to it. It is used in benches and in FPGA bring-up, running in the controller's clock domain and oversampling spi_clk with clk.

Parameters:
ADDR_BITS, 12, byte-array size is 2**ADDR_BITS; the 24-bit SPI address is truncated to these LSBs, so accesses wrap.
DUMMY_CLKS, 6, SPI clocks between the address and data phases of a 0xEB read; the mode byte occupies the first 2 of them.
ALLOW_WRITE, 1, when 0, command 0x38 is treated as unknown (flash model).

Ports:
clk  input  1  system clock; the same clock that drives the controller.
rst  input  1  synchronous reset, active high.
spi_clk  input  1  SPI clock from the controller.
spi_select  input  1  chip select, active low.
spi_data_out  input  4  controller-driven IO lines.
spi_data_in  output  4  responder-driven IO lines, routed to the controller's spi_data_in.
spi_data_oe_r  output  4  responder output enable; the bench checks it for bus contention.
cont_mode  output  1  continuous-read mode is armed.
busy  output  1  responder is in any state other than IDLE.
bd_we  input  1  backdoor write strobe.
bd_addr  input  ADDR_BITS  backdoor address.
bd_wdata  input  8  backdoor write data.
bd_rdata  output  8  combinational read of mem[bd_addr].

Behaviour:
- Reset: state=IDLE; spi_data_in=0; spi_data_oe_r=0; cont_mode=0; busy=0; spi_clk_prev=0. The memory array is not reset.
- Edge detection: spi_clk_prev is registered every clk.
  - Rise = spi_clk & ~spi_clk_prev; fall = ~spi_clk & spi_clk_prev.
  - spi_clk high and low phases must each last at least 1 clk.
  - Inputs are sampled in the clk cycle where rise is detected.
- Deselect: spi_select=1 in any cycle sends the state to IDLE on the next clk and clears oe. A partially received nibble or byte is discarded; cont_mode is kept.
- IDLE: on the first clk with spi_select=0, go to ADDR if cont_mode=1, else CMD. Clear the bit/nibble counters.
- CMD: 8 rises, serial MSB-first on spi_data_out[0]. After the 8th rise:
  - 0xEB goes to ADDR with read=1.
  - 0x38 goes to ADDR with read=0, only if ALLOW_WRITE=1.
  - 0xAB and 0x66 go to IGNORE with no effect.
  - Any other command goes to IGNORE.
- ADDR: 6 rises, one nibble per rise, MSB nibble first, forming a 24-bit address. After the 6th rise: read goes to DUMMY, write goes to WRITE.
  - A cont_mode entry is always a read.
- DUMMY: DUMMY_CLKS rises.
  - Nibbles on rises 1–2 form the mode byte. cont_mode is set to (mode[5:4]==2'b10) and is evaluated after rise 2.
  - After the last rise, go to READ.
- READ:
  - On each fall (including the fall after the final dummy rise), in the next clk drive spi_data_in with the next nibble, high nibble first. Set oe=4'hF from that clk.
  - After the low nibble, the address increments modulo 2**ADDR_BITS.
  - Data read in the same clk as a backdoor write to the same byte returns the old value.
- WRITE: nibble sampled on each rise, high first. On the low nibble's rise, mem[addr] is written in that clk and addr increments with wrap. oe stays 0.
- IGNORE: oe=0 and nothing is stored, until deselect.
- Backdoor: bd_we writes mem[bd_addr] on clk.
  - On a same-cycle collision with an SPI write commit to the same byte, the SPI write wins.
- oe is 0 in every state except READ, so there is no contention during CMD, ADDR or DUMMY.
- Reset mid-transaction: the next clk returns to IDLE with cont_mode=0 and the array intact.

Decomposition:
- Package qspi_resp_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE);
  - command constants CMD_QREAD=8'hEB and CMD_QWRITE=8'h38;
  - the cont-mode match value 2'b10.
- Sub-module qspi_resp_mem: a single-port sync-write, async-read byte array with a second async backdoor read port. Write-port arbitration (SPI over backdoor) happens in the parent.

Test Plan:
- Backdoor preload mem[0x010..0x013]=11,22,33,44. Send 0xEB, addr 0x000010, mode 0x00, 4 dummy clocks, then 8 data clocks. Required: nibbles 1,1,2,2,3,3,4,4 on spi_data_in; oe=F only in READ; cont_mode=0.
- Send 0x38, addr 0x000020, data nibbles A,B,C,D, then deselect. Required: bd_rdata at 0x020=AB and at 0x021=CD; oe=0 throughout.
- 0xEB read with mode 0xA0, deselect; then a new select with no command, addr 0x000010. Required: data 11,22 returned without a CMD phase. A following read with mode 0xFF clears cont_mode.
- Read at addr 0x000FFF (ADDR_BITS=12) for 2 bytes. Required: mem[0xFFF] then mem[0x000].
- Deselect after 3 write nibbles at addr 0x030 with mem[0x031]=5A. Required: byte at 0x030 written, mem[0x031] still 5A, state IDLE one clk later.
- Unknown command 0x9F, then 16 clocks with the controller driving IO. Required: oe=0 and array unchanged. Assert rst mid-READ: the next clk has busy=0, oe=0, cont_mode=0.

Source files
------------

// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QSPI memory responder.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRead,
        StWrite,
        StIgnore
    } state_e;

    localparam logic [7:0] CMD_QREAD       = 8'hEB;
    localparam logic [7:0] CMD_QWRITE      = 8'h38;
    localparam logic [1:0] CONT_MODE_MATCH = 2'b10;

endpackage

// File: rtl/qspi_resp_mem.sv
// Byte array: one synchronous write port, one async read port, one async backdoor read port.
module qspi_resp_mem #(
    parameter int unsigned AddrBits = 12
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AddrBits-1:0] waddr_i,
    input  logic [7:0]          wdata_i,
    input  logic [AddrBits-1:0] raddr_i,
    output logic [7:0]          rdata_o,
    input  logic [AddrBits-1:0] bd_raddr_i,
    output logic [7:0]          bd_rdata_o
);

    logic [7:0] mem_q [2**AddrBits];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign bd_rdata_o = mem_q[bd_raddr_i];

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI flash/PSRAM device model: decodes CMD/ADDR/DUMMY phases and serves reads or commits writes.
module qspi_mem_responder
    import qspi_resp_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned DUMMY_CLKS  = 6,
    parameter bit          ALLOW_WRITE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_select,
    input  logic [3:0]           spi_data_out,
    output logic [3:0]           spi_data_in,
    output logic [3:0]           spi_data_oe_r,
    output logic                 cont_mode,
    output logic                 busy,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam int unsigned    CntW      = 8;
    localparam logic [CntW-1:0] DummyLast = CntW'(DUMMY_CLKS - 1);

    state_e                state_q, state_d;
    logic                  spi_clk_prev_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [6:0]            cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  read_q, read_d;
    logic [3:0]            nib_q, nib_d;
    logic                  lo_q, lo_d;
    logic                  cont_q, cont_d;
    logic [3:0]            data_q, data_d;
    logic [3:0]            oe_q, oe_d;

    logic                  rise, fall;
    logic [7:0]            cmd_shift;
    logic                  spi_we;
    logic [7:0]            spi_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [7:0]            mem_wdata;

    assign rise      = spi_clk & ~spi_clk_prev_q;
    assign fall      = ~spi_clk & spi_clk_prev_q;
    assign cmd_shift = {cmd_q, spi_data_out[0]};
    assign spi_wdata = {nib_q, spi_data_out};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        read_d  = read_q;
        nib_d   = nib_q;
        lo_d    = lo_q;
        cont_d  = cont_q;
        data_d  = data_q;
        oe_d    = oe_q;
        spi_we  = 1'b0;

        if (spi_select) begin
            state_d = StIdle;
            oe_d    = 4'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    lo_d    = 1'b0;
                    read_d  = 1'b1;
                    state_d = cont_q ? StAddr : StCmd;
                end
                StCmd: if (rise) begin
                    cmd_d = cmd_shift[6:0];
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(7)) begin
                        cnt_d = '0;
                        if (cmd_shift == CMD_QREAD) begin
                            read_d  = 1'b1;
                            state_d = StAddr;
                        end else if (ALLOW_WRITE && cmd_shift == CMD_QWRITE) begin
                            read_d  = 1'b0;
                            state_d = StAddr;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StAddr: if (rise) begin
                    // Shifting into an ADDR_BITS-wide register keeps only the address LSBs.
                    addr_d = {addr_q[ADDR_BITS-5:0], spi_data_out};
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(5)) begin
                        cnt_d   = '0;
                        lo_d    = 1'b0;
                        state_d = read_q ? StDummy : StWrite;
                    end
                end
                StDummy: if (rise) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(0)) begin
                        nib_d = spi_data_out;
                    end
                    // mode[5:4] lives in the low bits of the first mode nibble.
                    if (cnt_q == CntW'(1)) begin
                        cont_d = (nib_q[1:0] == CONT_MODE_MATCH);
                    end
                    if (cnt_q == DummyLast) begin
                        cnt_d   = '0;
                        lo_d    = 1'b0;
                        state_d = StRead;
                    end
                end
                StRead: if (fall) begin
                    oe_d   = 4'hF;
                    data_d = lo_q ? mem_rdata[3:0] : mem_rdata[7:4];
                    lo_d   = ~lo_q;
                    if (lo_q) begin
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end
                StWrite: if (rise) begin
                    lo_d = ~lo_q;
                    if (!lo_q) begin
                        nib_d = spi_data_out;
                    end else begin
                        spi_we = 1'b1;
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            spi_clk_prev_q <= 1'b0;
            cnt_q          <= '0;
            cmd_q          <= '0;
            addr_q         <= '0;
            read_q         <= 1'b1;
            nib_q          <= '0;
            lo_q           <= 1'b0;
            cont_q         <= 1'b0;
            data_q         <= '0;
            oe_q           <= '0;
        end else begin
            state_q        <= state_d;
            spi_clk_prev_q <= spi_clk;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            read_q         <= read_d;
            nib_q          <= nib_d;
            lo_q           <= lo_d;
            cont_q         <= cont_d;
            data_q         <= data_d;
            oe_q           <= oe_d;
        end
    end

    // SPI writes take priority over the backdoor on the shared write port.
    assign mem_we    = spi_we | bd_we;
    assign mem_waddr = spi_we ? addr_q : bd_addr;
    assign mem_wdata = spi_we ? spi_wdata : bd_wdata;

    qspi_resp_mem #(
        .AddrBits(ADDR_BITS)
    ) u_mem (
        .clk_i     (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_i   (addr_q),
        .rdata_o   (mem_rdata),
        .bd_raddr_i(bd_addr),
        .bd_rdata_o(bd_rdata)
    );

    assign spi_data_in   = data_q;
    assign spi_data_oe_r = oe_q;
    assign cont_mode     = cont_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: reads, writes, continuous mode, wrap, abort and reset.
module tb_qspi_mem_responder;

    localparam int unsigned AB = 12;
    localparam int unsigned DC = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_select = 1'b1;
    logic [3:0]    spi_data_out = 4'h0;
    logic [3:0]    spi_data_in;
    logic [3:0]    spi_data_oe_r;
    logic          cont_mode;
    logic          busy;
    logic          bd_we = 1'b0;
    logic [AB-1:0] bd_addr = '0;
    logic [7:0]    bd_wdata = 8'h00;
    logic [7:0]    bd_rdata;

    int            checks = 0;
    int            errors = 0;
    logic [3:0]    rd_nib;
    logic [3:0]    rd_oe;
    logic [3:0]    oe_seen;
    logic [31:0]   rdata;
    logic [3:0]    oe_and;
    logic [7:0]    bval;

    qspi_mem_responder #(
        .ADDR_BITS  (AB),
        .DUMMY_CLKS (DC),
        .ALLOW_WRITE(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_clk      (spi_clk),
        .spi_select   (spi_select),
        .spi_data_out (spi_data_out),
        .spi_data_in  (spi_data_in),
        .spi_data_oe_r(spi_data_oe_r),
        .cont_mode    (cont_mode),
        .busy         (busy),
        .bd_we        (bd_we),
        .bd_addr      (bd_addr),
        .bd_wdata     (bd_wdata),
        .bd_rdata     (bd_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SPI clock: data set while low, sampled by both sides at the rising edge.
    task automatic spi_cyc(input logic [3:0] d);
        spi_data_out = d;
        repeat (2) @(posedge clk);
        #1;
        spi_clk = 1'b1;
        rd_nib  = spi_data_in;
        rd_oe   = spi_data_oe_r;
        oe_seen = oe_seen | spi_data_oe_r;
        repeat (2) @(posedge clk);
        #1;
        spi_clk = 1'b0;
    endtask

    task automatic select_dev();
        spi_select = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic deselect_dev();
        spi_select = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) spi_cyc({3'b000, c[i]});
    endtask

    task automatic send_addr_dummy(input logic [23:0] a, input logic [7:0] mode, input bit rd);
        for (int i = 5; i >= 0; i--) spi_cyc(a[i*4 +: 4]);
        if (rd) begin
            spi_cyc(mode[7:4]);
            spi_cyc(mode[3:0]);
            for (int i = 0; i < DC - 2; i++) spi_cyc(4'h0);
        end
    endtask

    task automatic read_nibs(input int n, output logic [31:0] data, output logic [3:0] oa);
        data = '0;
        oa   = 4'hF;
        for (int i = 0; i < n; i++) begin
            spi_cyc(4'h0);
            data = {data[27:0], rd_nib};
            oa   = oa & rd_oe;
        end
    endtask

    task automatic bd_write(input logic [AB-1:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [AB-1:0] a, output logic [7:0] d);
        bd_addr = a;
        #1;
        d = bd_rdata;
    endtask

    initial begin
        oe_seen = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_oe", {28'b0, spi_data_oe_r}, 32'h0);
        check("reset_data_in", {28'b0, spi_data_in}, 32'h0);
        check("reset_cont", {31'b0, cont_mode}, 32'd0);

        bd_write(12'h010, 8'h11);
        bd_write(12'h011, 8'h22);
        bd_write(12'h012, 8'h33);
        bd_write(12'h013, 8'h44);
        bd_write(12'hFFF, 8'h9C);
        bd_write(12'h000, 8'h7E);
        bd_write(12'h030, 8'h00);
        bd_write(12'h031, 8'h5A);

        // Plain quad read of four bytes.
        select_dev();
        oe_seen = 4'h0;
        send_cmd(8'hEB);
        send_addr_dummy(24'h000010, 8'h00, 1'b1);
        check("read_hdr_oe", {28'b0, oe_seen}, 32'h0);
        check("read_busy", {31'b0, busy}, 32'd1);
        read_nibs(8, rdata, oe_and);
        check("read_data", rdata, 32'h11223344);
        check("read_oe", {28'b0, oe_and}, 32'hF);
        check("read_cont", {31'b0, cont_mode}, 32'd0);
        deselect_dev();
        check("desel_busy", {31'b0, busy}, 32'd0);
        check("desel_oe", {28'b0, spi_data_oe_r}, 32'h0);

        // Quad write of two bytes.
        select_dev();
        oe_seen = 4'h0;
        send_cmd(8'h38);
        send_addr_dummy(24'h000020, 8'h00, 1'b0);
        spi_cyc(4'hA);
        spi_cyc(4'hB);
        spi_cyc(4'hC);
        spi_cyc(4'hD);
        deselect_dev();
        check("write_oe", {28'b0, oe_seen}, 32'h0);
        bd_read(12'h020, bval);
        check("write_b0", {24'b0, bval}, 32'hAB);
        bd_read(12'h021, bval);
        check("write_b1", {24'b0, bval}, 32'hCD);

        // Arm continuous mode, then a command-less read that disarms it.
        select_dev();
        send_cmd(8'hEB);
        send_addr_dummy(24'h000010, 8'hA0, 1'b1);
        read_nibs(2, rdata, oe_and);
        check("cont_arm_data", rdata, 32'h11);
        check("cont_armed", {31'b0, cont_mode}, 32'd1);
        deselect_dev();
        check("cont_kept", {31'b0, cont_mode}, 32'd1);
        select_dev();
        oe_seen = 4'h0;
        send_addr_dummy(24'h000010, 8'hFF, 1'b1);
        check("cont_hdr_oe", {28'b0, oe_seen}, 32'h0);
        read_nibs(4, rdata, oe_and);
        check("cont_data", rdata, 32'h1122);
        check("cont_cleared", {31'b0, cont_mode}, 32'd0);
        deselect_dev();

        // Address wrap at the top of the array, and 24-bit address truncation.
        select_dev();
        send_cmd(8'hEB);
        send_addr_dummy(24'h000FFF, 8'h00, 1'b1);
        read_nibs(4, rdata, oe_and);
        check("wrap_data", rdata, 32'h9C7E);
        deselect_dev();
        select_dev();
        send_cmd(8'hEB);
        send_addr_dummy(24'h456011, 8'h00, 1'b1);
        read_nibs(2, rdata, oe_and);
        check("trunc_data", rdata, 32'h22);
        deselect_dev();

        // Write aborted after three nibbles.
        select_dev();
        send_cmd(8'h38);
        send_addr_dummy(24'h000030, 8'h00, 1'b0);
        spi_cyc(4'h6);
        spi_cyc(4'h9);
        spi_cyc(4'h3);
        spi_select = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle", {31'b0, busy}, 32'd0);
        bd_read(12'h030, bval);
        check("abort_b0", {24'b0, bval}, 32'h69);
        bd_read(12'h031, bval);
        check("abort_b1", {24'b0, bval}, 32'h5A);
        repeat (2) @(posedge clk);
        #1;

        // Unknown command: ignore everything until deselect.
        select_dev();
        oe_seen = 4'h0;
        send_cmd(8'h9F);
        for (int i = 0; i < 16; i++) spi_cyc(4'(i));
        check("ign_oe", {28'b0, oe_seen}, 32'h0);
        check("ign_busy", {31'b0, busy}, 32'd1);
        deselect_dev();
        bd_read(12'h010, bval);
        check("ign_mem10", {24'b0, bval}, 32'h11);
        bd_read(12'h000, bval);
        check("ign_mem00", {24'b0, bval}, 32'h7E);

        // Reset in the middle of a read with continuous mode armed.
        select_dev();
        send_cmd(8'hEB);
        send_addr_dummy(24'h000012, 8'hA0, 1'b1);
        spi_cyc(4'h0);
        check("rst_pre_nib", {28'b0, rd_nib}, 32'h3);
        check("rst_pre_oe", {28'b0, spi_data_oe_r}, 32'hF);
        check("rst_pre_cont", {31'b0, cont_mode}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_oe", {28'b0, spi_data_oe_r}, 32'h0);
        check("rst_cont", {31'b0, cont_mode}, 32'd0);
        rst = 1'b0;
        spi_select = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bd_read(12'h012, bval);
        check("rst_mem", {24'b0, bval}, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
